// File: rtl/lz77_ctrl_pkg.sv
// Shared definitions for the LZ77 encoder job scheduler: FSM states,
// the string terminator, abort codes and the default counter width.
package lz77_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  // Every job string ends with '$'.
  localparam logic [7:0] END_CHAR = 8'h24;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNDERRUN = 2'd1;
  localparam logic [1:0] ERR_OVERLEN  = 2'd2;
  localparam logic [1:0] ERR_WDOG     = 2'd3;

  localparam int DEF_CNT_W = 14;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The source granted last loses priority
// when the pointer is updated; after reset source 0 is preferred.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       req_any,
  output logic       idx
);

  // prio = 1 means source 1 wins a tie
  logic prio;

  // Pick a source: tie broken by the pointer, otherwise the lone requester
  always_comb begin
    req_any = req[0] | req[1];
    if (req[0] && req[1]) begin
      idx = prio;
    end else if (req[1]) begin
      idx = 1'b1;
    end else begin
      idx = 1'b0;
    end
  end

  // Hand priority to the other source once a grant is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (update && req_any) begin
      prio <= ~idx;
    end else begin
      prio <= prio;
    end
  end

endmodule

// File: rtl/lz77_job_scheduler.sv
// Shares one LZ77 encoder between two string sources: arbitrates, keeps
// the encoder in reset while idle, streams the granted string into it
// one character per cycle, counts emitted tokens and reports the result.
module lz77_job_scheduler
  import lz77_ctrl_pkg::*;
#(
  parameter int MAX_LEN     = 8193,
  parameter int WDOG_CYCLES = 1048575,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [7:0]       src0_data,
  input  logic             src0_valid,
  output logic             src0_ready,
  input  logic [7:0]       src1_data,
  input  logic             src1_valid,
  output logic             src1_ready,
  output logic             enc_reset,
  output logic [7:0]       enc_chardata,
  input  logic             enc_valid,
  input  logic             enc_finish,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] tok_cnt,
  output logic             done,
  output logic             done_id,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int               WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LEN_LIM = CNT_W'(MAX_LEN);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = '1;

  state_t           state, state_nx;
  logic [1:0]       abort_code;
  logic             sel;          // latched source of the current job
  logic             cur_valid;
  logic [7:0]       cur_data;
  logic             ready_cur;
  logic             take;         // character handshake this cycle
  logic [CNT_W-1:0] cap_cnt;      // load count after this cycle's capture
  logic [CNT_W-1:0] load_cnt;
  logic [WD_W-1:0]  wd_cnt;       // RUN cycles already spent
  logic             arb_any;
  logic             arb_idx;
  logic             arb_update;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign arb_update = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .update  (arb_update),
    .req_any (arb_any),
    .idx     (arb_idx)
  );

  // Source mux and handshake; ready drops once '$' is already on the encoder
  always_comb begin
    cur_valid = sel ? src1_valid : src0_valid;
    cur_data  = sel ? src1_data : src0_data;
    case (state)
      ST_GRANT: ready_cur = 1'b1;
      ST_LOAD:  ready_cur = (enc_chardata != END_CHAR);
      default:  ready_cur = 1'b0;
    endcase
    take       = ready_cur & cur_valid;
    cap_cnt    = (state == ST_GRANT) ? CNT_W'(1) : inc_sat(load_cnt);
    src0_ready = ready_cur & ~sel;
    src1_ready = ready_cur & sel;
  end

  // Next-state logic and abort cause
  always_comb begin
    state_nx   = state;
    abort_code = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (arb_any) state_nx = ST_GRANT;
        else         state_nx = ST_IDLE;
      end
      ST_GRANT: begin
        if (!take) begin
          state_nx = ST_GRANT;
        end else if (cap_cnt >= LEN_LIM && cur_data != END_CHAR) begin
          state_nx   = ST_ABORT;
          abort_code = ERR_OVERLEN;
        end else begin
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (enc_chardata == END_CHAR) begin
          state_nx = ST_RUN;
        end else if (!cur_valid) begin
          // the encoder consumes a character every cycle and cannot wait
          state_nx   = ST_ABORT;
          abort_code = ERR_UNDERRUN;
        end else if (cap_cnt >= LEN_LIM && cur_data != END_CHAR) begin
          state_nx   = ST_ABORT;
          abort_code = ERR_OVERLEN;
        end else begin
          state_nx = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (enc_finish) begin
          state_nx = ST_DONE;
        end else if (wd_cnt >= WD_LAST) begin
          state_nx   = ST_ABORT;
          abort_code = ERR_WDOG;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      ST_ABORT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Latch the granted source for the whole job
  always_ff @(posedge clk) begin
    if (reset) begin
      sel   <= 1'b0;
      grant <= 2'b00;
    end else if (state == ST_IDLE && arb_any) begin
      sel   <= arb_idx;
      grant <= arb_idx ? 2'b10 : 2'b01;
    end else if (state_nx == ST_IDLE) begin
      sel   <= sel;
      grant <= 2'b00;
    end else begin
      sel   <= sel;
      grant <= grant;
    end
  end

  // Encoder pins: out of reset only while loading or running
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_reset    <= 1'b1;
      enc_chardata <= 8'h00;
    end else begin
      enc_reset    <= !(state_nx == ST_LOAD || state_nx == ST_RUN);
      enc_chardata <= (state_nx == ST_LOAD) ? cur_data : 8'h00;
    end
  end

  // Load and watchdog counters
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      load_cnt <= take ? cap_cnt : load_cnt;
      if (state != ST_RUN)      wd_cnt <= '0;
      else if (wd_cnt == WD_MAX) wd_cnt <= wd_cnt;
      else                       wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Token counter: cleared when a new job is granted, saturating in RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_cnt <= '0;
    end else if (state == ST_IDLE && arb_any) begin
      tok_cnt <= '0;
    end else if (state == ST_RUN && enc_valid) begin
      tok_cnt <= inc_sat(tok_cnt);
    end else begin
      tok_cnt <= tok_cnt;
    end
  end

  // One-cycle completion / abort reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      done_id  <= 1'b0;
    end else begin
      done     <= (state_nx == ST_DONE);
      err      <= (state_nx == ST_ABORT);
      err_code <= (state_nx == ST_ABORT) ? abort_code : ERR_NONE;
      if (state_nx == ST_DONE || state_nx == ST_ABORT) done_id <= sel;
      else                                             done_id <= done_id;
    end
  end

endmodule

// File: tb/tb_lz77_job_scheduler.sv
// Self-checking bench for lz77_job_scheduler with small MAX_LEN and
// watchdog limits. Jobs come from a directed table plus random jobs whose
// expected outcome is predicted from the string/token plan.
module tb_lz77_job_scheduler;

  localparam int         MAX_LEN = 8;
  localparam int         WDOG    = 16;
  localparam int         CNT_W   = 14;
  localparam logic [7:0] DOLLAR  = 8'h24;

  typedef struct packed {
    logic [1:0]      req;
    logic            drop;      // release req right after the grant
    logic [3:0]      nval;      // characters offered before valid drops
    logic [9:0][7:0] chars;
    logic [4:0]      ntok;      // enc_valid on RUN cycles 0..ntok-1
    logic [4:0]      fin_cyc;   // RUN cycle carrying enc_finish (>=WDOG: never)
    logic            exp_src;
    logic [1:0]      exp_code;
    logic [4:0]      exp_tok;
  } job_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [7:0]       src0_data, src1_data;
  logic             src0_valid, src1_valid, src0_ready, src1_ready;
  logic             enc_reset;
  logic [7:0]       enc_chardata;
  logic             enc_valid, enc_finish;
  logic [1:0]       grant;
  logic             busy;
  logic [CNT_W-1:0] tok_cnt;
  logic             done, done_id, err;
  logic [1:0]       err_code;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   last_src;
  job_t tbl [10];

  lz77_job_scheduler #(.MAX_LEN(MAX_LEN), .WDOG_CYCLES(WDOG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .enc_reset(enc_reset), .enc_chardata(enc_chardata),
    .enc_valid(enc_valid), .enc_finish(enc_finish),
    .grant(grant), .busy(busy), .tok_cnt(tok_cnt), .done(done),
    .done_id(done_id), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input bit s);
    return s ? 2'b10 : 2'b01;
  endfunction

  // Granted source gets (v,d); the other source keeps offering junk.
  task automatic drive(input bit s, input bit v, input logic [7:0] d);
    if (s) begin
      src1_valid = v;    src1_data = d;
      src0_valid = 1'b1; src0_data = 8'h5A;
    end else begin
      src0_valid = v;    src0_data = d;
      src1_valid = 1'b1; src1_data = 8'h5A;
    end
  endtask

  function automatic job_t mk(input logic [1:0] r, input bit drop, input string str,
                              input int ntok, input int fin, input bit esrc,
                              input int ecode, input int etok);
    job_t j = '0;
    j.req  = r;
    j.drop = drop;
    j.nval = 4'(str.len());
    for (int i = 0; i < str.len(); i++) j.chars[i] = str[i];
    j.ntok     = 5'(ntok);
    j.fin_cyc  = 5'(fin);
    j.exp_src  = esrc;
    j.exp_code = 2'(ecode);
    j.exp_tok  = 5'(etok);
    return j;
  endfunction

  // Outcome from the job plan: arbitration, then string legality, then tokens.
  function automatic job_t predict(input job_t j, input bit last);
    job_t r   = j;
    int   nv  = int'(j.nval);
    int   lim = (nv < MAX_LEN) ? nv : MAX_LEN;
    int   q   = -1;
    int   nt  = int'(j.ntok);
    int   fc  = int'(j.fin_cyc);
    r.exp_src = (j.req == 2'b11) ? ~last : j.req[1];
    for (int i = lim - 1; i >= 0; i--) if (j.chars[i] == DOLLAR) q = i;
    if (q < 0) begin
      r.exp_code = (nv >= MAX_LEN) ? 2'd2 : 2'd1;
      r.exp_tok  = 5'd0;
    end else if (fc < WDOG) begin
      r.exp_code = 2'd0;
      r.exp_tok  = 5'((nt < fc + 1) ? nt : fc + 1);
    end else begin
      r.exp_code = 2'd3;
      r.exp_tok  = 5'((nt < WDOG) ? nt : WDOG);
    end
    return r;
  endfunction

  // Run one job from IDLE back to IDLE, checking every cycle.
  task automatic run_job(input job_t j);
    bit s = j.exp_src;
    int k;
    int code = 0;
    bit load_end = 1'b0;
    req = j.req;
    step();
    chk("grant", 32'(grant), 32'(onehot(s)));
    chk("grant_busy", 32'(busy), 32'd1);
    chk("grant_enc_reset", 32'(enc_reset), 32'd1);
    chk("grant_tok_clr", 32'(tok_cnt), 32'd0);
    chk("grant_ready", 32'({src1_ready, src0_ready}), 32'(onehot(s)));
    if (j.drop) req = 2'b00;
    drive(s, 1'b1, j.chars[0]);
    step();
    k = 1;
    while (code == 0 && !load_end) begin
      chk("load_data", 32'(enc_chardata), 32'(j.chars[k-1]));
      chk("load_enc_reset", 32'(enc_reset), 32'd0);
      chk("load_grant", 32'(grant), 32'(onehot(s)));
      if (j.chars[k-1] == DOLLAR) begin
        chk("load_ready_end", 32'({src1_ready, src0_ready}), 32'd0);
        drive(s, 1'b0, 8'h00);
        step();
        load_end = 1'b1;
      end else begin
        chk("load_ready", 32'({src1_ready, src0_ready}), 32'(onehot(s)));
        if (k < int'(j.nval)) begin
          drive(s, 1'b1, j.chars[k]);
          step();
          k++;
          if (k == MAX_LEN && j.chars[k-1] != DOLLAR) code = 2;
        end else begin
          drive(s, 1'b0, 8'h00);
          step();
          code = 1;
        end
      end
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    if (code == 0) begin
      for (int c = 0; c < WDOG; c++) begin
        chk("run_data", 32'(enc_chardata), 32'd0);
        chk("run_enc_reset", 32'(enc_reset), 32'd0);
        chk("run_ready", 32'({src1_ready, src0_ready}), 32'd0);
        enc_valid  = (c < int'(j.ntok));
        enc_finish = (c == int'(j.fin_cyc));
        step();
        if (enc_finish) break;
        if (c == WDOG - 1) code = 3;
      end
      enc_valid  = 1'b0;
      enc_finish = 1'b0;
    end
    if (j.exp_code == 2'd0) begin
      chk("done", 32'(done), 32'd1);
      chk("done_no_err", 32'(err), 32'd0);
    end else begin
      chk("err", 32'(err), 32'd1);
      chk("err_code", 32'(err_code), 32'(j.exp_code));
      chk("err_no_done", 32'(done), 32'd0);
    end
    chk("done_id", 32'(done_id), 32'(s));
    chk("tok_cnt", 32'(tok_cnt), 32'(j.exp_tok));
    chk("end_enc_reset", 32'(enc_reset), 32'd1);
    chk("end_busy", 32'(busy), 32'd1);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_pulses", 32'({done, err}), 32'd0);
    chk("idle_enc_reset", 32'(enc_reset), 32'd1);
    chk("idle_tok_hold", 32'(tok_cnt), 32'(j.exp_tok));
  endtask

  initial begin
    job_t j;
    reset = 1'b1; req = 2'b00;
    src0_valid = 1'b0; src1_valid = 1'b0; src0_data = 8'h00; src1_data = 8'h00;
    enc_valid = 1'b0; enc_finish = 1'b0;

    //              req   drop string       ntok fin src code tok
    tbl[0] = mk(2'b11, 1'b0, "A$",        1,  0,  1'b0, 0, 1);
    tbl[1] = mk(2'b11, 1'b0, "BC$",       2,  4,  1'b1, 0, 2);
    tbl[2] = mk(2'b11, 1'b0, "$",         0,  2,  1'b0, 0, 0);
    tbl[3] = mk(2'b01, 1'b0, "ABA$",      3,  3,  1'b0, 0, 3);
    tbl[4] = mk(2'b10, 1'b0, "AB",        0,  0,  1'b1, 1, 0);
    tbl[5] = mk(2'b01, 1'b0, "ABCDEFGHI", 0,  0,  1'b0, 2, 0);
    tbl[6] = mk(2'b01, 1'b0, "$",         1,  0,  1'b0, 0, 1);
    tbl[7] = mk(2'b10, 1'b0, "Z$",        3,  31, 1'b1, 3, 3);
    tbl[8] = mk(2'b01, 1'b1, "QR$",       2,  1,  1'b0, 0, 2);
    tbl[9] = mk(2'b10, 1'b0, "ABCDEFG$",  0,  0,  1'b1, 0, 0);

    @(negedge clk);
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enc_reset", 32'(enc_reset), 32'd1);
    chk("rst_outputs", 32'({enc_chardata, grant, done, done_id, err, err_code}), 32'd0);
    chk("rst_tok", 32'(tok_cnt), 32'd0);
    chk("rst_ready", 32'({src1_ready, src0_ready}), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_no_req", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) run_job(tbl[i]);
    req = 2'b00;

    // Reset in the middle of a src0 job; pointer must return to src0 first.
    req = 2'b01;
    step();
    chk("mid_grant", 32'(grant), 32'd1);
    drive(1'b0, 1'b1, DOLLAR);
    step();
    drive(1'b0, 1'b0, 8'h00);
    step();
    chk("mid_run_enc_reset", 32'(enc_reset), 32'd0);
    enc_valid = 1'b1;
    step();
    enc_valid = 1'b0;
    reset = 1'b1; req = 2'b00; src0_valid = 1'b0; src1_valid = 1'b0;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_enc_reset", 32'(enc_reset), 32'd1);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_pulses", 32'({done, err}), 32'd0);
    chk("mid_rst_tok", 32'(tok_cnt), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_after_pulses", 32'({done, err, busy}), 32'd0);
    last_src = 1'b1;
    j = predict(mk(2'b11, 1'b0, "K$", 2, 2, 1'b0, 0, 0), last_src);
    run_job(j);
    last_src = j.exp_src;

    for (int n = 0; n < 40; n++) begin
      j         = '0;
      j.req     = 2'($urandom_range(1, 3));
      j.drop    = ($urandom_range(0, 3) == 0);
      j.nval    = 4'($urandom_range(1, 9));
      for (int i = 0; i < 10; i++) j.chars[i] = 8'(32'h41 + $urandom_range(0, 25));
      begin
        int p = int'($urandom_range(0, 11));
        if (p < 10) j.chars[p] = DOLLAR;
      end
      j.ntok    = 5'($urandom_range(0, 8));
      j.fin_cyc = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
      j = predict(j, last_src);
      run_job(j);
      last_src = j.exp_src;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lz77_job_scheduler.md
# lz77_job_scheduler

Job scheduler that shares one LZ77 encoder between two character-stream requesters. Grants the encoder round-robin, holds it in reset while idle, streams the granted string (terminated by `$`, 0x24) one character per cycle into the encoder, counts emitted tokens and reports job completion or abort. Sits between the upstream string sources and the encoder's `reset`/`chardata`/`valid`/`finish` pins.

## Interface
- `MAX_LEN`, 8193: maximum characters per job including the `$`.
- `WDOG_CYCLES`, 1048575: maximum cycles in RUN before abort.
- `CNT_W`, 14: width of the load and token counters.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  2  per-source "job pending" flag.
- `src0_data` / `src1_data`  in  8  source character.
- `src0_valid` / `src1_valid`  in  1  character valid.
- `src0_ready` / `src1_ready`  out  1  scheduler accepts character; combinational from state.
- `enc_reset`  out  1  encoder reset; registered.
- `enc_chardata`  out  8  encoder character input; registered.
- `enc_valid`  in  1  encoder token strobe.
- `enc_finish`  in  1  encoder finished flag.
- `grant`  out  2  one-hot active source, 0 when idle.
- `busy`  out  1  state != IDLE.
- `tok_cnt`  out  CNT_W  tokens of current/last job.
- `done`  out  1  one-cycle job-complete pulse.
- `done_id`  out  1  source index of the completed/aborted job.
- `err`  out  1  one-cycle abort pulse.
- `err_code`  out  2  1 = underrun, 2 = overlength, 3 = watchdog; valid with `err`.

## Operation
- States: IDLE, GRANT, LOAD, RUN, DONE, ABORT.
- `enc_reset` = 1 in IDLE, GRANT, DONE and ABORT; 0 in LOAD and RUN.
- IDLE: if any `req` bit is set, the arbiter picks a source and the FSM goes to GRANT. Round-robin: the last-granted source gets lower priority. After reset, src0 has priority. Simultaneous requests alternate 0,1,0,...
- GRANT: `srcN_ready`=1. The FSM waits indefinitely for `srcN_valid`; the encoder stays in reset. On the handshake it captures the character into `enc_chardata`, sets the load count to 1, and goes to LOAD.
- LOAD: `srcN_ready` = (`enc_chardata` != 0x24).
  - Each handshake captures the next character and increments the load count.
  - If `enc_chardata` == 0x24 this cycle, go to RUN.
  - If ready=1 and valid=0, ABORT with code 1 (underrun). The encoder cannot stall.
  - If the load count reaches MAX_LEN and the captured character is not 0x24, ABORT with code 2.
- RUN: `enc_chardata` = 0x00. `tok_cnt` increments on each `enc_valid`.
  - On `enc_finish`, go to DONE.
  - If the RUN cycle count reaches WDOG_CYCLES, ABORT with code 3.
- DONE: `done`=1 and `done_id` set for one cycle, then IDLE. `tok_cnt` holds until the next GRANT clears it to 0.
- ABORT: `err`=1 with `err_code` and `done_id` for one cycle, then IDLE. No `done` pulse.
- Grant is latched for the whole job. Dropping `req` after GRANT has no effect.
- Counters saturate at their maximum and never wrap.

## Timing
- Reset values:
  - state IDLE, `enc_reset`=1.
  - `enc_chardata`, `grant`, `busy`, `tok_cnt`, `done`, `done_id`, `err`, `err_code` all 0.
  - Round-robin pointer prefers src0.
- Reset mid-job: on the next cycle the FSM is in IDLE with `enc_reset`=1, and neither `done` nor `err` pulses.
- `req` seen in IDLE at edge k: GRANT at k+1, with `srcN_ready` high in that cycle.
- Character accepted at edge k appears on `enc_chardata` from k+1, with `enc_reset`=0 in the same cycle. Latency is 1.
- `enc_reset` is high for at least 2 cycles between jobs (DONE/ABORT + IDLE).
- A `$` presented in GRANT (empty string) gives exactly one LOAD cycle, then RUN.
- If `enc_valid` and `enc_finish` arrive in the same cycle, the token is counted.

## Structure
- Shared package `lz77_ctrl_pkg` holds:
  - the state enum;
  - `END_CHAR` = 8'h24;
  - the `err_code` constants;
  - the default `CNT_W`.
- One sub-module, `rr_arb2`: a two-way round-robin arbiter with a pointer update-on-grant input.
- The FSM, counters and data registers live in `lz77_job_scheduler`.

## Test plan
- **Single job:** src0 sends 41,42,41,24. Required: `grant`=01; `enc_chardata` shows 41,42,41,24 on consecutive cycles with `enc_reset`=0. A model encoder gives 3 `enc_valid` then `enc_finish`. Then `done`=1, `done_id`=0, `tok_cnt`=3, and `enc_reset` returns to 1.
- **Arbitration:** both `req` held high over three jobs. Required: grants 01, 10, 01. No GRANT overlaps a RUN.
- **Underrun:** src1 sends 41,42, then `src1_valid`=0. Required: `err`=1, `err_code`=1, `done_id`=1, `enc_reset`=1 on the next cycle, no `done`.
- **Overlength:** MAX_LEN=8, eight non-0x24 characters. Required: `err_code`=2 after the 8th capture; `src_ready` drops.
- **Empty string:** src0 sends only 24. Required: one LOAD cycle, then RUN. A model gives 1 valid plus finish, giving `tok_cnt`=1 and `done`=1.
- **Reset and watchdog:**
  - `reset` during RUN: next cycle `busy`=0, `enc_reset`=1, `grant`=0.
  - WDOG_CYCLES=16 with no `enc_finish`: `err_code`=3 at cycle 16.
